regfile_wb_arb: RTL and testbench
=================================

# regfile_wb_arb

Write-back arbiter for the 32×32 register file write port. Shares the single `regW`/`Wdat`/`RegWrite` port between NREQ write-back requesters (ALU, load unit, link/exception unit) using round-robin arbitration and a one-entry registered output stage. Sits between the execute/memory stages and the register file. Optionally keeps a pending-write scoreboard for the issue stage.

## Interface
- NREQ, 3, number of write-back requesters (2..8)
- REG_W, 5, register index width
- DAT_W, 32, data width
- btn  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  freeze write port: no grants, output stage holds, RegWrite forced 0
- req_valid  in  NREQ  per-requester write request
- req_regW  in  NREQ*REG_W  destination index, requester i at [i*REG_W +: REG_W]
- req_dat  in  NREQ*DAT_W  write data, requester i at [i*DAT_W +: DAT_W]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- regW  out  REG_W  register file write index
- Wdat  out  DAT_W  register file write data
- RegWrite  out  1  register file write enable
- grant_id  out  3  index of requester whose write is in the output stage
- rsv_valid, rsv_reg, pending: see Configuration

## Operation
- Reset: output stage invalid; regW=0, Wdat=0, RegWrite=0, grant_id=0, req_ready=0, RR pointer=NREQ-1, so requester 0 has top priority first.
- Arbitration (combinational): when hold=0, search starts at pointer+1 mod NREQ; first requester with req_valid=1 gets req_ready=1. At most one req_ready bit high. No requests or hold=1 → req_ready=0.
- On handshake at a rising edge: output stage loads {regW, Wdat, grant_id} from the winner, stage valid=1, pointer=winner index.
- No handshake and hold=0: stage valid=0 (write already issued), regW/Wdat/grant_id retain last values.
- hold=1: stage content and valid unchanged; pointer unchanged.
- RegWrite = stage valid & ~hold & (regW != 0). Writes to r0 are accepted and consumed but never assert RegWrite.
- Requesters must keep req_valid, req_regW, req_dat stable until handshake; the arbiter never revokes req_ready within a cycle while inputs are stable.
- Duplicate destination from two requesters: serialized in grant order; the later grant wins in the register file.

## Timing
- Latency: handshake at edge n → RegWrite high during cycle n+1; register file captures at the falling edge of btn inside that cycle; data readable from cycle n+1 second half.
- Throughput: one write per cycle with hold=0; a requester held valid continuously alternates with any other valid requester (no starvation, worst wait NREQ-1 cycles).
- hold asserted while stage valid: RegWrite drops immediately (combinational); the pending write issues in the first cycle with hold=0.
- rst asserted mid-operation: stage, pointer and scoreboard clear immediately; an in-flight write is lost (register file is cleared by the same reset).

## Configuration
- REGFILE_WB_SCOREBOARD_EN defined: adds ports rsv_valid (in, 1), rsv_reg (in, REG_W), pending (out, 32). A rising edge with rsv_valid=1 and rsv_reg!=0 sets pending[rsv_reg]; a cycle with RegWrite=1 clears pending[regW] at the next edge. Set and clear of the same index in one cycle: set wins. pending[0] is always 0. Reset: pending=0.
- Not defined: ports and logic absent; behaviour otherwise identical.

## Structure
- Package regfile_pkg: REG_W, DAT_W, NREG=32, and the typedef for the output-stage record {valid, regW, Wdat, grant_id}; shared with the register file and issue stage.
- Sub-module rr_arbiter (parameter N): req vector, pointer in → one-hot grant and encoded index out; purely combinational, reused by the memory-port arbiter.

## Test plan
- Reset: rst=1 mid-stream → RegWrite=0, regW=0, Wdat=0, req_ready=0; after release, only req_valid[2]=1 (regW=5, dat=0x1234) → req_ready=3'b100, next cycle RegWrite=1, regW=5, Wdat=0x1234.
- Round-robin: all three valid continuously (regs 1,2,3) → grants 0,1,2,0,1,2; RegWrite for reg 1,2,3,1 in consecutive cycles.
- r0 write: req 1 writes regW=0, dat=0xFFFFFFFF → handshake completes, RegWrite stays 0 in following cycle.
- Hold: stage holds reg 7 data 0xA5A5A5A5, hold=1 for 3 cycles → RegWrite=0, req_ready=0, regW/Wdat unchanged; hold=0 → RegWrite=1 one cycle, reg 7 written once.
- Same destination: req0 and req1 both target reg 4 (0x11, 0x22), pointer favouring req0 → reg 4 ends 0x22.
- Scoreboard (macro on): rsv reg 9 → pending[9]=1; write of reg 9 committed while rsv_reg=9 reissued same cycle → pending[9] stays 1; rsv_reg=0 → pending[0] stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: index/data widths, register count and the
// write-back output-stage record used by the arbiter, register file and issue stage.
package regfile_pkg;
   localparam int unsigned REG_W = 5;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned NREG  = 32;
   localparam int unsigned GID_W = 3;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] regW;
      logic [DAT_W-1:0] Wdat;
      logic [GID_W-1:0] grant_id;
   } wb_stage_t;
endpackage

// File: rtl/regfile_wb_arb_rr_arbiter.sv
// Combinational round-robin arbiter: search begins one past ptr and wraps; returns
// a one-hot grant plus its encoded index. Shared with the memory-port arbiter.
module rr_arbiter #(
   parameter  int unsigned N  = 3,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   int unsigned j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!any && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            any      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arb.sv
// Round-robin write-back arbiter with a one-entry output stage driving the
// register file write port. Optional pending-write scoreboard: REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arb #(
   parameter int unsigned NREQ  = 3,
   parameter int unsigned REG_W = 5,
   parameter int unsigned DAT_W = 32
) (
   input  logic                  btn,
   input  logic                  rst,
   input  logic                  hold,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*REG_W-1:0] req_regW,
   input  logic [NREQ*DAT_W-1:0] req_dat,
   output logic [NREQ-1:0]       req_ready,
   output logic [REG_W-1:0]      regW,
   output logic [DAT_W-1:0]      Wdat,
   output logic                  RegWrite,
   output logic [2:0]            grant_id
`ifdef REGFILE_WB_SCOREBOARD_EN
   ,
   input  logic                  rsv_valid,
   input  logic [REG_W-1:0]      rsv_reg,
   output logic [31:0]           pending
`endif
);

   localparam int unsigned PW = $clog2(NREQ);

   regfile_pkg::wb_stage_t stage_q, stage_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] grant;
   logic [PW-1:0]   win_idx;
   logic            win_any;

   // Reset also masks grants so req_ready reads 0 while rst is high.
   assign arb_req = req_valid & {NREQ{~(hold | rst)}};

   rr_arbiter #(.N(NREQ)) u_arb (
      .req   (arb_req),
      .ptr   (ptr_q),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   always_comb begin
      stage_d = stage_q;
      ptr_d   = ptr_q;
      if (!hold) begin
         if (win_any) begin
            stage_d.valid    = 1'b1;
            stage_d.regW     = req_regW[32'(win_idx)*REG_W +: REG_W];
            stage_d.Wdat     = req_dat[32'(win_idx)*DAT_W +: DAT_W];
            stage_d.grant_id = 3'(win_idx);
            ptr_d            = win_idx;
         end else begin
            stage_d.valid = 1'b0;
         end
      end
   end

   always_ff @(posedge btn or posedge rst) begin
      if (rst) begin
         stage_q <= '0;
         ptr_q   <= PW'(NREQ - 1);
      end else begin
         stage_q <= stage_d;
         ptr_q   <= ptr_d;
      end
   end

   assign req_ready = grant;
   assign regW      = stage_q.regW;
   assign Wdat      = stage_q.Wdat;
   assign grant_id  = stage_q.grant_id;
   assign RegWrite  = stage_q.valid & ~hold & (stage_q.regW != '0);

`ifdef REGFILE_WB_SCOREBOARD_EN
   logic [regfile_pkg::NREG-1:0] pending_q, pending_d;

   // Clear applied before set so a same-index reservation wins.
   always_comb begin
      pending_d = pending_q;
      if (RegWrite) pending_d[regW] = 1'b0;
      if (rsv_valid && (rsv_reg != '0)) pending_d[rsv_reg] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge btn or posedge rst) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   assign pending = pending_q;
`endif

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Bench for regfile_wb_arb: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural arbiter model.
module tb_regfile_wb_arb;

   localparam int NREQ = 3;

   logic          btn = 1'b0;
   logic          rst = 1'b1;
   logic          hold = 1'b0;
   logic [2:0]    req_valid = '0;
   logic [14:0]   req_regW = '0;
   logic [95:0]   req_dat = '0;
   logic [2:0]    req_ready;
   logic [4:0]    regW;
   logic [31:0]   Wdat;
   logic          RegWrite;
   logic [2:0]    grant_id;
   logic          rsv_valid = 1'b0;
   logic [4:0]    rsv_reg = '0;
   logic [31:0]   pending;

   regfile_wb_arb #(.NREQ(3), .REG_W(5), .DAT_W(32)) dut (
      .btn       (btn),
      .rst       (rst),
      .hold      (hold),
      .req_valid (req_valid),
      .req_regW  (req_regW),
      .req_dat   (req_dat),
      .req_ready (req_ready),
      .regW      (regW),
      .Wdat      (Wdat),
      .RegWrite  (RegWrite),
      .grant_id  (grant_id)
`ifdef REGFILE_WB_SCOREBOARD_EN
      ,
      .rsv_valid (rsv_valid),
      .rsv_reg   (rsv_reg),
      .pending   (pending)
`endif
   );

   always #5 btn = ~btn;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: last winner, pending write record, register contents.
   int          m_last = NREQ - 1;
   logic        m_valid = 1'b0;
   logic [4:0]  m_regW = '0;
   logic [31:0] m_Wdat = '0;
   logic [2:0]  m_gid = '0;
   logic [2:0]  m_gnt = '0;
   logic [31:0] m_pend = '0;
   logic [31:0] rf [32];
   logic [31:0] dut_rf [32];
   int          dut_w7cnt = 0;

   function automatic int pick(input logic [2:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (last + k) % NREQ;
         if (v[j]) return j;
      end
      return -1;
   endfunction

   initial begin
      for (int r = 0; r < 32; r++) begin rf[r] = '0; dut_rf[r] = '0; end
   end

   always @(posedge btn or posedge rst) begin
      int w;
      if (rst) begin
         m_last = NREQ - 1; m_valid = 0; m_regW = 0; m_Wdat = 0; m_gid = 0;
         m_gnt = 0; m_pend = 0;
         for (int r = 0; r < 32; r++) begin rf[r] = '0; dut_rf[r] = '0; end
      end else begin
         m_gnt = 0;
         if (m_valid && !hold && m_regW != 0) begin
            rf[m_regW] = m_Wdat;
            m_pend[m_regW] = 1'b0;
         end
         if (rsv_valid && rsv_reg != 0) m_pend[rsv_reg] = 1'b1;
         if (!hold) begin
            w = pick(req_valid, m_last);
            if (w >= 0) begin
               m_valid = 1; m_regW = req_regW[w*5 +: 5]; m_Wdat = req_dat[w*32 +: 32];
               m_gid = 3'(w); m_last = w; m_gnt[w] = 1'b1;
            end else begin
               m_valid = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   always @(negedge btn) begin
      logic [2:0] er;
      logic       erw;
      int         w;
      er = '0;
      if (!rst && !hold) begin
         w = pick(req_valid, m_last);
         if (w >= 0) er[w] = 1'b1;
      end
      erw = m_valid && !hold && (m_regW != 0);
      chk("req_ready", 64'(req_ready), 64'(er));
      chk("RegWrite", 64'(RegWrite), 64'(erw));
      chk("regW", 64'(regW), 64'(m_regW));
      chk("Wdat", 64'(Wdat), 64'(m_Wdat));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
`ifdef REGFILE_WB_SCOREBOARD_EN
      chk("pending", 64'(pending), 64'(m_pend));
`endif
      if (RegWrite) begin
         dut_rf[regW] = Wdat;
         if (regW == 5'd7) dut_w7cnt++;
      end
   end

   task automatic step;
      @(posedge btn); #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
      req_valid[i] = 1'b1;
      req_regW[i*5 +: 5] = r;
      req_dat[i*32 +: 32] = d;
   endtask

   initial begin
      // Reset state
      step; step;
      @(negedge btn);
      chk("rst_RegWrite", 64'(RegWrite), 64'd0);
      chk("rst_regW", 64'(regW), 64'd0);
      chk("rst_Wdat", 64'(Wdat), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      step; rst = 0;

      // Single requester 2 after reset
      set_req(2, 5'd5, 32'h1234);
      @(negedge btn); chk("first_ready", 64'(req_ready), 64'b100);
      step; req_valid = '0;
      @(negedge btn);
      chk("first_RegWrite", 64'(RegWrite), 64'd1);
      chk("first_regW", 64'(regW), 64'd5);
      chk("first_Wdat", 64'(Wdat), 64'h1234);
      step;

      // Round robin, all three continuously valid
      set_req(0, 5'd1, 32'h101); set_req(1, 5'd2, 32'h202); set_req(2, 5'd3, 32'h303);
      for (int k = 0; k < 7; k++) begin
         @(negedge btn);
         chk("rr_grant", 64'(req_ready), 64'(3'b001 << (k % 3)));
         if (k > 0) begin
            chk("rr_RegWrite", 64'(RegWrite), 64'd1);
            chk("rr_regW", 64'(regW), 64'(((k - 1) % 3) + 1));
         end
         step;
      end
      req_valid = '0;
      @(negedge btn); chk("rr_last_regW", 64'(regW), 64'd1);
      step;

      // Write to r0 is consumed without RegWrite
      set_req(1, 5'd0, 32'hFFFF_FFFF);
      @(negedge btn); chk("r0_ready", 64'(req_ready), 64'b010);
      step; req_valid = '0;
      @(negedge btn);
      chk("r0_RegWrite", 64'(RegWrite), 64'd0);
      chk("r0_grant_id", 64'(grant_id), 64'd1);
      step;

      // Hold freezes a pending reg 7 write for three cycles
      set_req(0, 5'd7, 32'hA5A5_A5A5);
      @(negedge btn); chk("hold_pre_ready", 64'(req_ready), 64'b001);
      step; req_valid = '0; set_req(2, 5'd10, 32'hBEEF); hold = 1;
      for (int k = 0; k < 3; k++) begin
         @(negedge btn);
         chk("hold_RegWrite", 64'(RegWrite), 64'd0);
         chk("hold_ready", 64'(req_ready), 64'd0);
         chk("hold_regW", 64'(regW), 64'd7);
         chk("hold_Wdat", 64'(Wdat), 64'hA5A5_A5A5);
         step;
      end
      hold = 0;
      @(negedge btn);
      chk("unhold_RegWrite", 64'(RegWrite), 64'd1);
      chk("unhold_regW", 64'(regW), 64'd7);
      chk("unhold_ready", 64'(req_ready), 64'b100);
      step; req_valid = '0;
      @(negedge btn); chk("reg7_write_count", 64'(dut_w7cnt), 64'd1);
      step;

      // Same destination from two requesters
      set_req(0, 5'd4, 32'h11); set_req(1, 5'd4, 32'h22);
      @(negedge btn); chk("dup_ready0", 64'(req_ready), 64'b001);
      step; req_valid[0] = 1'b0;
      @(negedge btn); chk("dup_ready1", 64'(req_ready), 64'b010);
      step; req_valid = '0;
      step;
      chk("dup_dut_reg4", 64'(dut_rf[4]), 64'h22);
      chk("dup_model_reg4", 64'(rf[4]), 64'h22);

`ifdef REGFILE_WB_SCOREBOARD_EN
      rsv_valid = 1; rsv_reg = 5'd9;
      step; rsv_valid = 0; set_req(0, 5'd9, 32'h99);
      @(negedge btn); chk("sb_set9", 64'(pending[9]), 64'd1);
      step; req_valid = '0; rsv_valid = 1; rsv_reg = 5'd9;
      @(negedge btn); chk("sb_wr9", 64'(RegWrite && regW == 5'd9), 64'd1);
      step; rsv_reg = 5'd0;
      @(negedge btn); chk("sb_keep9", 64'(pending[9]), 64'd1);
      step; rsv_valid = 0;
      @(negedge btn); chk("sb_r0", 64'(pending[0]), 64'd0);
      step;
`endif

      // Reset while a write sits in the output stage
      set_req(0, 5'd12, 32'h77);
      step; req_valid = '0; #1 rst = 1; #1;
      chk("midrst_RegWrite", 64'(RegWrite), 64'd0);
      chk("midrst_regW", 64'(regW), 64'd0);
      chk("midrst_Wdat", 64'(Wdat), 64'd0);
      chk("midrst_ready", 64'(req_ready), 64'd0);
      step; rst = 0;

      // Randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (m_gnt[i] || !req_valid[i]) begin
               if ($urandom_range(0, 2) != 0)
                  set_req(i, 5'($urandom_range(0, 31)), $urandom);
               else
                  req_valid[i] = 1'b0;
            end
         end
         hold      = ($urandom_range(0, 4) == 0);
         rsv_valid = ($urandom_range(0, 2) == 0);
         rsv_reg   = ($urandom_range(0, 3) == 0) ? regW : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 59) == 0) begin
            #2 rst = 1;
         end
         step;
         rst = 0;
      end
      req_valid = '0; hold = 0;
      step; step;

      begin
         int nmis;
         nmis = 0;
         for (int r = 0; r < 32; r++) if (dut_rf[r] !== rf[r]) nmis++;
         chk("rf_contents", 64'(nmis), 64'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
